// File: rtl/ama_riscv_pkg.sv
// ama_riscv_pkg: shared register-file geometry constants
package ama_riscv_pkg;
  localparam int XLEN    = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_NUM = 1 << ADDR_W;
endpackage

// File: rtl/ama_riscv_scoreboard.sv
// ama_riscv_scoreboard: per-register busy mask; set wins over clears, x0 never busy
// ports: i_set_* marks a pending write, i_clr_a_*/i_clr_b_* retire one, o_busy_* are lookups
module ama_riscv_scoreboard
  import ama_riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_a_en,
  input  logic [ADDR_W-1:0] i_clr_a_addr,
  input  logic              i_clr_b_en,
  input  logic [ADDR_W-1:0] i_clr_b_addr,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  input  logic [ADDR_W-1:0] i_rd,
  output logic              o_busy_rs1,
  output logic              o_busy_rs2,
  output logic              o_busy_rd
);
  logic [REG_NUM-1:0] r_busy;
  logic [REG_NUM-1:0] w_set;
  logic [REG_NUM-1:0] w_clr;
  always_comb begin
    w_set = '0;
    w_clr = '0;
    w_set[i_set_addr] = i_set_en;
    w_clr[i_clr_a_addr] = i_clr_a_en;
    w_clr[i_clr_b_addr] = w_clr[i_clr_b_addr] | i_clr_b_en;
  end
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= ((r_busy & ~w_clr) | w_set) & {{(REG_NUM-1){1'b1}}, 1'b0};
  end
  assign o_busy_rs1 = r_busy[i_rs1];
  assign o_busy_rs2 = r_busy[i_rs2];
  assign o_busy_rd  = r_busy[i_rd];
endmodule

// File: rtl/ama_riscv_operand_fetch.sv
// ama_riscv_operand_fetch: decode-stage reg-file reader with writeback bypass, busy scoreboard and registered operand output
// ports: i_in_* issue side, o_rf_addr_*/i_rf_data_* reg-file read, i_wb_* writeback, i_flush, i_out_ready/o_out_* execute side
module ama_riscv_operand_fetch
  import ama_riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [ADDR_W-1:0] i_in_rs1,
  input  logic [ADDR_W-1:0] i_in_rs2,
  input  logic [ADDR_W-1:0] i_in_rd,
  input  logic              i_in_rd_we,
  output logic [ADDR_W-1:0] o_rf_addr_a,
  output logic [ADDR_W-1:0] o_rf_addr_b,
  input  logic [XLEN-1:0]   i_rf_data_a,
  input  logic [XLEN-1:0]   i_rf_data_b,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0]   i_wb_data,
  input  logic              i_flush,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [XLEN-1:0]   o_out_rs1_data,
  output logic [XLEN-1:0]   o_out_rs2_data,
  output logic [ADDR_W-1:0] o_out_rd,
  output logic              o_out_rd_we
);
  logic              r_valid;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [ADDR_W-1:0] r_rd;
  logic              r_rd_we;
  logic w_hit_rs1, w_hit_rs2, w_hit_rd;
  logic w_busy_rs1, w_busy_rs2, w_busy_rd;
  logic w_hazard, w_fire, w_out_fire, w_flush_clr;
  logic [XLEN-1:0] w_op_a, w_op_b;
  assign o_rf_addr_a = i_in_rs1;
  assign o_rf_addr_b = i_in_rs2;
  assign w_hit_rs1 = i_wb_we & (i_wb_addr == i_in_rs1);
  assign w_hit_rs2 = i_wb_we & (i_wb_addr == i_in_rs2);
  assign w_hit_rd  = i_wb_we & (i_wb_addr == i_in_rd);
  // the register file writes synchronously, so a same-cycle writeback is not yet visible on its read ports
  assign w_op_a = (i_in_rs1 == '0) ? '0 : w_hit_rs1 ? i_wb_data : i_rf_data_a;
  assign w_op_b = (i_in_rs2 == '0) ? '0 : w_hit_rs2 ? i_wb_data : i_rf_data_b;
  assign w_hazard = (w_busy_rs1 & (i_in_rs1 != '0) & ~w_hit_rs1)
                  | (w_busy_rs2 & (i_in_rs2 != '0) & ~w_hit_rs2)
                  | (i_in_rd_we & w_busy_rd & (i_in_rd != '0) & ~w_hit_rd);
  assign o_in_ready  = ~rst & ~i_flush & ~w_hazard & (~r_valid | i_out_ready);
  assign w_fire      = i_in_valid & o_in_ready;
  assign w_out_fire  = r_valid & i_out_ready;
  // a flushed instruction that never reached execute will never write back, so release its rd
  assign w_flush_clr = i_flush & r_valid & r_rd_we & (r_rd != '0) & ~i_out_ready;
  ama_riscv_scoreboard u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_set_en     (w_fire & i_in_rd_we & (i_in_rd != '0)),
    .i_set_addr   (i_in_rd),
    .i_clr_a_en   (i_wb_we & (i_wb_addr != '0)),
    .i_clr_a_addr (i_wb_addr),
    .i_clr_b_en   (w_flush_clr),
    .i_clr_b_addr (r_rd),
    .i_rs1        (i_in_rs1),
    .i_rs2        (i_in_rs2),
    .i_rd         (i_in_rd),
    .o_busy_rs1   (w_busy_rs1),
    .o_busy_rs2   (w_busy_rs2),
    .o_busy_rd    (w_busy_rd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rd       <= '0;
      r_rd_we    <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_valid    <= 1'b1;
      r_rs1_data <= w_op_a;
      r_rs2_data <= w_op_b;
      r_rd       <= i_in_rd;
      r_rd_we    <= i_in_rd_we;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end
  assign o_out_valid    = r_valid;
  assign o_out_rs1_data = r_rs1_data;
  assign o_out_rs2_data = r_rs2_data;
  assign o_out_rd       = r_rd;
  assign o_out_rd_we    = r_rd_we;
endmodule

// File: tb/tb_ama_riscv_operand_fetch.sv
// tb_ama_riscv_operand_fetch: directed stimulus with a queue scoreboard for the operand-fetch stage
module tb_ama_riscv_operand_fetch;
  import ama_riscv_pkg::*;
  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [ADDR_W-1:0] rd;
    logic              we;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_rd_we, wb_we, flush, out_valid, out_ready, out_rd_we;
  logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd, rf_addr_a, rf_addr_b, wb_addr, out_rd;
  logic [XLEN-1:0] rf_data_a, rf_data_b, wb_data, out_rs1_data, out_rs2_data;
  logic [XLEN-1:0] tb_rf [REG_NUM];
  logic [REG_NUM-1:0] busy;
  exp_t q[$];
  exp_t e;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ama_riscv_operand_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_rs1       (in_rs1),
    .i_in_rs2       (in_rs2),
    .i_in_rd        (in_rd),
    .i_in_rd_we     (in_rd_we),
    .o_rf_addr_a    (rf_addr_a),
    .o_rf_addr_b    (rf_addr_b),
    .i_rf_data_a    (rf_data_a),
    .i_rf_data_b    (rf_data_b),
    .i_wb_we        (wb_we),
    .i_wb_addr      (wb_addr),
    .i_wb_data      (wb_data),
    .i_flush        (flush),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_rs1_data (out_rs1_data),
    .o_out_rs2_data (out_rs2_data),
    .o_out_rd       (out_rd),
    .o_out_rd_we    (out_rd_we)
  );
  assign busy = dut.u_sb.r_busy;
  assign rf_data_a = tb_rf[in_rs1];
  assign rf_data_b = tb_rf[in_rs2];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++)
        tb_rf[i] <= (i == 0) ? 32'hFFFF_FFFF : (i == 5) ? 32'h0000_1234 : (i == 6) ? 32'h0000_ABCD : 32'hA000_0000 | (i * 32'h0101);
    end else if (wb_we && wb_addr != '0) begin
      tb_rf[wb_addr] <= wb_data;
    end
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && (out_ready || flush)) begin
        if (q.size() == 0) chk("sb_underflow", 64'(q.size()), 64'd1);
        else begin
          e = q.pop_front();
          if (out_ready) begin
            chk("sb_rs1", out_rs1_data, e.a);
            chk("sb_rs2", out_rs2_data, e.b);
            chk("sb_rd", out_rd, e.rd);
            chk("sb_rd_we", out_rd_we, e.we);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.a  = (in_rs1 == 0) ? 32'd0 : (wb_we && wb_addr == in_rs1) ? wb_data : tb_rf[in_rs1];
        e.b  = (in_rs2 == 0) ? 32'd0 : (wb_we && wb_addr == in_rs2) ? wb_data : tb_rf[in_rs2];
        e.rd = in_rd;
        e.we = in_rd_we;
        q.push_back(e);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    #3;
  endtask
  task automatic drive(input int rs1, input int rs2, input int rd, input bit we);
    in_valid = 1'b1;
    in_rs1 = ADDR_W'(rs1);
    in_rs2 = ADDR_W'(rs2);
    in_rd = ADDR_W'(rd);
    in_rd_we = we;
  endtask
  task automatic wb(input bit we, input int addr, input logic [XLEN-1:0] data);
    wb_we = we;
    wb_addr = ADDR_W'(addr);
    wb_data = data;
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
    wb(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); mid();
      chk("rst_in_ready", in_ready, 0);
    end
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rs1_data", out_rs1_data, 0);
    chk("rst_rd", {out_rd, out_rd_we}, 0);
    cyc(); rst = 1'b0; mid();
    chk("ready_after_rst", in_ready, 1);
    cyc(); drive(5, 6, 7, 1); mid();
    chk("plain_ready", in_ready, 1);
    cyc(); in_valid = 1'b0; mid();
    chk("plain_valid", out_valid, 1);
    chk("plain_rs1", out_rs1_data, 32'h1234);
    chk("plain_rs2", out_rs2_data, 32'hABCD);
    chk("plain_rd", out_rd, 7);
    chk("plain_busy7", busy[7], 1);
    cyc(); drive(7, 5, 8, 1); mid();
    chk("raw_stall0", in_ready, 0);
    cyc(); mid();
    chk("raw_stall1", in_ready, 0);
    cyc(); wb(1, 7, 32'hDEAD_BEEF); mid();
    chk("raw_bypass_ready", in_ready, 1);
    cyc(); in_valid = 1'b0; wb(0, 0, 0); mid();
    chk("raw_rs1", out_rs1_data, 32'hDEAD_BEEF);
    chk("raw_rs2", out_rs2_data, 32'h1234);
    chk("raw_busy7", busy[7], 0);
    chk("raw_busy8", busy[8], 1);
    cyc(); wb(1, 8, 32'h8888_8888);
    cyc(); wb(0, 0, 0); mid();
    chk("raw_busy_clear", busy, 0);
    cyc(); drive(0, 0, 0, 1); wb(1, 0, 32'h5555_5555); mid();
    chk("x0_ready", in_ready, 1);
    cyc(); mid();
    chk("x0_rs1", out_rs1_data, 0);
    chk("x0_rs2", out_rs2_data, 0);
    chk("x0_busy", busy, 0);
    chk("x0_no_stall", in_ready, 1);
    cyc(); in_valid = 1'b0; wb(0, 0, 0);
    cyc(); drive(1, 2, 10, 1);
    cyc(); drive(3, 4, 10, 1); mid();
    chk("waw_stall", in_ready, 0);
    cyc(); wb(1, 10, 32'h1010_1010); mid();
    chk("waw_bypass_ready", in_ready, 1);
    cyc(); in_valid = 1'b0; wb(1, 10, 32'h2020_2020); mid();
    chk("waw_set_wins", busy[10], 1);
    cyc(); wb(0, 0, 0); mid();
    chk("waw_busy_clear", busy, 0);
    cyc(); out_ready = 1'b0; drive(1, 2, 11, 1);
    cyc(); drive(3, 4, 12, 1);
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_hold_rs1", out_rs1_data, tb_rf[1]);
      chk("bp_hold_rd", out_rd, 11);
      cyc();
    end
    out_ready = 1'b1; mid();
    chk("bp_release_ready", in_ready, 1);
    cyc(); in_valid = 1'b0; mid();
    chk("bp_next_rd", out_rd, 12);
    cyc(); wb(1, 11, 32'h1111_0000);
    cyc(); wb(1, 12, 32'h1212_0000);
    cyc(); wb(0, 0, 0); mid();
    chk("bp_busy_clear", busy, 0);
    cyc(); out_ready = 1'b0; drive(1, 2, 9, 1);
    cyc(); in_valid = 1'b0; flush = 1'b1; mid();
    chk("fl_busy9_before", busy[9], 1);
    chk("fl_ready", in_ready, 0);
    cyc(); flush = 1'b0; drive(9, 1, 13, 1); mid();
    chk("fl_valid", out_valid, 0);
    chk("fl_busy9", busy[9], 0);
    chk("fl_issue", in_ready, 1);
    cyc(); in_valid = 1'b0; out_ready = 1'b1; mid();
    chk("fl_next_rd", out_rd, 13);
    cyc(); out_ready = 1'b0; drive(1, 2, 14, 1); mid();
    chk("rst2_issue", in_ready, 1);
    cyc(); in_valid = 1'b0; rst = 1'b1; mid();
    chk("rst2_ready", in_ready, 0);
    cyc(); rst = 1'b0; out_ready = 1'b1; mid();
    chk("rst2_valid", out_valid, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_rs1_data", out_rs1_data, 0);
    cyc(); cyc(); mid();
    chk("sb_empty", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
